// File: rtl/motion_sequencer_if.sv
// ----------------------------------------------------------------------------
// motion_sequencer_if
// Command channel into the motion sequencer: a valid/ready handshake that
// carries four signed 16-bit wheel speeds and a hold duration in ticks.
//   cmd_valid  command offered by the producer
//   cmd_ready  sequencer can take the command this cycle
//   cmd_speed  {BR,BL,FR,FL} target speeds, each signed 16-bit
//   cmd_dur    hold time in control ticks, unsigned
// master: command producer; slave: the sequencer.
// ----------------------------------------------------------------------------
interface motion_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_speed;
  logic [15:0] cmd_dur;

  modport master (
    output cmd_valid,
    output cmd_speed,
    output cmd_dur,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_speed,
    input  cmd_dur,
    output cmd_ready
  );
endinterface

// File: rtl/motion_sequencer.sv
// ----------------------------------------------------------------------------
// motion_sequencer
// Queues wheel-speed commands and plays them out as slew-limited setpoints.
// Each command ramps all four channels toward its target once per control
// tick, holds for cmd_dur ticks, then moves to the next queued command or
// ramps back to zero. estop zeroes the setpoints and flushes everything.
// Ports:
//   clk       single clock
//   rst       asynchronous active-high reset
//   cmd       command channel (motion_sequencer_if.slave)
//   estop     emergency stop, level, synchronous to clk
//   sp        wheel setpoints {BR,BL,FR,FL}, signed 16-bit each
//   sp_valid  one-cycle pulse in the cycle sp takes a new value
//   done      one-cycle pulse when a command's hold completes
//   busy      sequencer is not idle
//   level     number of queued commands
// ----------------------------------------------------------------------------
module motion_sequencer #(
  parameter int TICK_DIV = 100000,
  parameter int DEPTH    = 4,
  parameter int SLEW     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  motion_sequencer_if.slave        cmd,
  input  logic                     estop,
  output logic [63:0]              sp,
  output logic                     sp_valid,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TICK_DIV);

  localparam logic signed [16:0] SLEW_S = 17'(SLEW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RAMP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] STOP = 2'd3;

  // Move one channel toward its target by at most SLEW. The difference is
  // taken at 17 bits so full-scale swings (e.g. +32767 to -32768) cannot wrap.
  function automatic logic [15:0] step_ch(input logic [15:0] cur, input logic [15:0] tgt);
    logic signed [16:0] cur_x;
    logic signed [16:0] diff;
    logic signed [16:0] res;
    cur_x = {cur[15], cur};
    diff  = $signed({tgt[15], tgt}) - cur_x;
    if (diff > SLEW_S) begin
      res = cur_x + SLEW_S;
    end else if (diff < -SLEW_S) begin
      res = cur_x - SLEW_S;
    end else begin
      res = $signed({tgt[15], tgt});
    end
    step_ch = res[15:0];
  endfunction

  // Apply step_ch to all four packed channels.
  function automatic logic [63:0] step4(input logic [63:0] cur, input logic [63:0] tgt);
    logic [63:0] res;
    res = 64'd0;
    for (int i = 0; i < 4; i++) begin
      res[16*i +: 16] = step_ch(cur[16*i +: 16], tgt[16*i +: 16]);
    end
    step4 = res;
  endfunction

  // Circular pointer advance that also works for non-trivial DEPTH=1.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      ptr_inc = {AW{1'b0}};
    end else begin
      ptr_inc = p + AW'(1);
    end
  endfunction

  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;

  logic [79:0]   fifo_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [79:0]   head_s;
  logic          ready_en_r;

  logic [1:0]    state_r;
  logic [63:0]   target_r;
  logic [15:0]   dur_r;
  logic [15:0]   hold_r;
  logic [63:0]   sp_r;
  logic          sp_valid_r;
  logic          done_r;
  logic          busy_r;

  logic [1:0]    state_next_s;
  logic [63:0]   target_next_s;
  logic [15:0]   dur_next_s;
  logic [15:0]   hold_next_s;
  logic [63:0]   sp_next_s;
  logic [63:0]   stepped_s;
  logic          done_next_s;

  assign tick_s  = (tick_cnt_r == TW'(TICK_DIV - 1));
  assign full_s  = (count_r == LW'(DEPTH));
  assign empty_s = (count_r == {LW{1'b0}});
  assign head_s  = fifo_mem_r[rd_ptr_r];

  // ready_en_r holds cmd_ready low through reset and for the first edge after it.
  assign cmd.cmd_ready = ready_en_r && !full_s && !estop;
  assign push_s        = cmd.cmd_valid && cmd.cmd_ready;
  assign stepped_s     = step4(sp_r, target_r);

  assign sp       = sp_r;
  assign sp_valid = sp_valid_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign level    = count_r;

  // Free-running control tick divider; estop does not disturb its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Command acceptance enable, released one edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Queue storage; contents are only meaningful below count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {cmd.cmd_speed, cmd.cmd_dur};
    end
  end

  // Queue pointers and occupancy; estop flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else if (estop) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencer next-state logic. RAMP/STOP step on a tick and leave in the
  // same tick that lands on the target, so an already-reached target exits on
  // the first tick. HOLD leaves as soon as the counter is zero (dur=0 never
  // waits for a tick).
  always_comb begin
    state_next_s  = state_r;
    target_next_s = target_r;
    dur_next_s    = dur_r;
    hold_next_s   = hold_r;
    sp_next_s     = sp_r;
    pop_s         = 1'b0;
    done_next_s   = 1'b0;
    if (estop) begin
      state_next_s  = IDLE;
      target_next_s = 64'd0;
      hold_next_s   = 16'd0;
      sp_next_s     = 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            pop_s         = 1'b1;
            target_next_s = head_s[79:16];
            dur_next_s    = head_s[15:0];
            state_next_s  = RAMP;
          end else begin
            state_next_s  = IDLE;
          end
        end
        RAMP: begin
          if (tick_s) begin
            sp_next_s = stepped_s;
            if (stepped_s == target_r) begin
              hold_next_s  = dur_r;
              state_next_s = HOLD;
            end else begin
              state_next_s = RAMP;
            end
          end else begin
            state_next_s = RAMP;
          end
        end
        HOLD: begin
          if (hold_r == 16'd0) begin
            done_next_s = 1'b1;
            if (!empty_s) begin
              pop_s         = 1'b1;
              target_next_s = head_s[79:16];
              dur_next_s    = head_s[15:0];
              state_next_s  = RAMP;
            end else begin
              target_next_s = 64'd0;
              state_next_s  = STOP;
            end
          end else if (tick_s) begin
            hold_next_s = hold_r - 16'd1;
          end else begin
            hold_next_s = hold_r;
          end
        end
        STOP: begin
          if (!empty_s) begin
            pop_s         = 1'b1;
            target_next_s = head_s[79:16];
            dur_next_s    = head_s[15:0];
            state_next_s  = RAMP;
          end else if (tick_s) begin
            sp_next_s = stepped_s;
            if (stepped_s == 64'd0) begin
              state_next_s = IDLE;
            end else begin
              state_next_s = STOP;
            end
          end else begin
            state_next_s = STOP;
          end
        end
        default: begin
          state_next_s  = IDLE;
          target_next_s = 64'd0;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      target_r   <= 64'd0;
      dur_r      <= 16'd0;
      hold_r     <= 16'd0;
      sp_r       <= 64'd0;
      sp_valid_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      target_r   <= target_next_s;
      dur_r      <= dur_next_s;
      hold_r     <= hold_next_s;
      sp_r       <= sp_next_s;
      sp_valid_r <= (sp_next_s != sp_r);
      done_r     <= done_next_s;
      busy_r     <= (state_next_s != IDLE);
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// ----------------------------------------------------------------------------
// tb_motion_sequencer
// Directed bench for motion_sequencer with TICK_DIV=4, SLEW=16, DEPTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_motion_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        estop = 1'b0;
  logic [63:0] sp;
  logic        sp_valid;
  logic        done;
  logic        busy;
  logic [2:0]  level;

  int checks = 0;
  int failures = 0;

  motion_sequencer_if cmd_bus ();

  motion_sequencer #(.TICK_DIV(4), .DEPTH(4), .SLEW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_bus),
    .estop    (estop),
    .sp       (sp),
    .sp_valid (sp_valid),
    .done     (done),
    .busy     (busy),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one command and hold it until accepted (bounded).
  task automatic push(input logic [63:0] spd, input logic [15:0] d);
    int n;
    n = 0;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_speed = spd;
    cmd_bus.cmd_dur   = d;
    #1;
    while (!cmd_bus.cmd_ready && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("push_accept", {63'd0, cmd_bus.cmd_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
  endtask

  // Advance to the next sp_valid pulse (bounded).
  task automatic wait_sv(input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sp_valid && n < max);
    chk("sv_wait", {63'd0, sp_valid}, 64'd1);
  endtask

  initial begin
    int n;
    int dones;
    int svs;
    int early;
    int prev;
    int expv;
    int steps;
    logic [15:0] e16;

    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_speed = 64'd0;
    cmd_bus.cmd_dur   = 16'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, cmd_bus.cmd_ready}, 64'd0);
    chk("rst_sp", sp, 64'd0);
    chk("rst_sv", {63'd0, sp_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_level", {61'd0, level}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, cmd_bus.cmd_ready}, 64'd1);

    // Single command FL=+40, dur=2
    push(64'd40, 16'd2);
    wait_sv(20);
    chk("ramp1", sp, 64'd16);
    @(negedge clk);
    chk("sv_pulse", {63'd0, sp_valid}, 64'd0);
    chk("busy_ramp", {63'd0, busy}, 64'd1);
    wait_sv(20);
    chk("ramp2", sp, 64'd32);
    wait_sv(20);
    chk("ramp3", sp, 64'd40);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    chk("hold_cycles", 64'(n), 64'd9);
    chk("hold_sp", sp, 64'd40);
    wait_sv(20);
    chk("stop1", sp, 64'd24);
    wait_sv(20);
    chk("stop2", sp, 64'd8);
    wait_sv(20);
    chk("stop3", sp, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_level", {61'd0, level}, 64'd0);

    // Queue fills while the first command holds
    push(64'd16, 16'd6);
    @(negedge clk);
    chk("a_popped", {61'd0, level}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      push(64'd16, 16'd0);
    end
    chk("full_level", {61'd0, level}, 64'd4);
    chk("full_ready", {63'd0, cmd_bus.cmd_ready}, 64'd0);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_speed = 64'd16;
    cmd_bus.cmd_dur   = 16'd0;
    #1;
    n = 0;
    while (!cmd_bus.cmd_ready && n < 80) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("fifth_ready", {63'd0, cmd_bus.cmd_ready}, 64'd1);
    chk("fifth_level", {61'd0, level}, 64'd3);
    chk("fifth_done", {63'd0, done}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    chk("fifth_pushed", {61'd0, level}, 64'd4);

    // Five dur=0 commands with equal targets drain without STOP
    dones = 0;
    svs = 0;
    early = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (done) dones++;
      if (sp_valid) begin
        svs++;
        if (dones < 5) early++;
      end
    end while (busy && n < 300);
    chk("drain_dones", 64'(dones), 64'd5);
    chk("drain_early_sv", 64'(early), 64'd0);
    chk("drain_sv", 64'(svs), 64'd1);
    chk("drain_sp", sp, 64'd0);

    // estop during HOLD with two commands queued
    push(64'd32, 16'd20);
    push(64'd100, 16'd0);
    push(64'd200, 16'd0);
    wait_sv(20);
    chk("e_ramp1", sp, 64'd16);
    wait_sv(20);
    chk("e_ramp2", sp, 64'd32);
    repeat (5) @(negedge clk);
    chk("e_level_pre", {61'd0, level}, 64'd2);
    estop = 1'b1;
    #1;
    chk("e_ready", {63'd0, cmd_bus.cmd_ready}, 64'd0);
    @(negedge clk);
    chk("e_sp", sp, 64'd0);
    chk("e_sv", {63'd0, sp_valid}, 64'd1);
    chk("e_level", {61'd0, level}, 64'd0);
    chk("e_busy", {63'd0, busy}, 64'd0);
    chk("e_done", {63'd0, done}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("e_hold_done", {63'd0, done}, 64'd0);
      chk("e_hold_sv", {63'd0, sp_valid}, 64'd0);
    end
    estop = 1'b0;
    #1;
    chk("e_release_ready", {63'd0, cmd_bus.cmd_ready}, 64'd1);
    push(64'h0000_0000_0000_FFEC, 16'd0);
    wait_sv(20);
    chk("neg1", sp, 64'h0000_0000_0000_FFF0);
    wait_sv(20);
    chk("neg2", sp, 64'h0000_0000_0000_FFEC);
    wait_sv(20);
    chk("neg3", sp, 64'h0000_0000_0000_FFFC);
    wait_sv(20);
    chk("neg4", sp, 64'd0);
    chk("neg_idle", {63'd0, busy}, 64'd0);

    // Signed extremes on BR: 0 -> +32767 -> -32768
    push(64'h7FFF_0000_0000_0000, 16'd0);
    push(64'h8000_0000_0000_0000, 16'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sp[63:48] !== 16'h7FFF && n < 9000);
    chk("ext_top", sp, 64'h7FFF_0000_0000_0000);
    prev = 32767;
    steps = 0;
    while (prev != -32768 && steps < 5000) begin
      wait_sv(10);
      expv = (prev - 16 < -32768) ? -32768 : prev - 16;
      e16 = 16'(expv);
      chk("ext_step", sp, {e16, 48'd0});
      prev = expv;
      steps++;
    end
    chk("ext_steps", 64'(steps), 64'd4096);

    // Reset mid-STOP, then reset mid-RAMP at sp=48
    rst = 1'b1;
    #1;
    chk("r1_sp", sp, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("r1_ready", {63'd0, cmd_bus.cmd_ready}, 64'd1);
    chk("r1_level", {61'd0, level}, 64'd0);
    push(64'd100, 16'd5);
    wait_sv(20);
    chk("r2_ramp1", sp, 64'd16);
    wait_sv(20);
    chk("r2_ramp2", sp, 64'd32);
    wait_sv(20);
    chk("r2_ramp3", sp, 64'd48);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("r2_sp", sp, 64'd0);
    chk("r2_sv", {63'd0, sp_valid}, 64'd0);
    chk("r2_done", {63'd0, done}, 64'd0);
    chk("r2_busy", {63'd0, busy}, 64'd0);
    chk("r2_level", {61'd0, level}, 64'd0);
    chk("r2_ready", {63'd0, cmd_bus.cmd_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("r2_after_level", {61'd0, level}, 64'd0);
    chk("r2_after_ready", {63'd0, cmd_bus.cmd_ready}, 64'd1);
    chk("r2_after_busy", {63'd0, busy}, 64'd0);
    repeat (12) @(negedge clk);
    chk("r2_no_resume_sp", sp, 64'd0);
    chk("r2_no_resume_busy", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/motion_sequencer.md
MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk cycles per control tick (1 ms at 100 MHz); legal values are 2 or more.
REQ-002 Parameter DEPTH, default 4, command queue depth; legal values are powers of 2.
REQ-003 Parameter SLEW, default 16, maximum setpoint change per channel per tick; legal values are 1 to 32767.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_speed  in  64  target wheel speeds {BR,BL,FR,FL}, each signed 16-bit.
REQ-009 cmd_dur  in  16  hold time in ticks, unsigned.
REQ-010 estop  in  1  emergency stop, level, already synchronous to clk.
REQ-011 sp  out  64  wheel setpoints {BR,BL,FR,FL}, each signed 16-bit, to the drive controller.
REQ-012 sp_valid  out  1  one-cycle pulse whenever sp changed value.
REQ-013 done  out  1  one-cycle pulse when a command's hold completes.
REQ-014 busy  out  1  high when state is not IDLE.
REQ-015 level  out  $clog2(DEPTH)+1  number of queued commands.

Function
REQ-016 Tick generator: free-running counter from reset that pulses tick for 1 cycle every TICK_DIV cycles; the first tick occurs TICK_DIV cycles after reset release.
REQ-017 Queue: FIFO of {cmd_speed,cmd_dur}; cmd_ready = !full && !estop.
REQ-018 Queue: push on a handshake; simultaneous push and pop in one cycle are both legal; level updates the cycle after.
REQ-019 FSM states are IDLE, RAMP, HOLD and STOP.
REQ-020 IDLE: if the queue is non-empty, pop it, load target and dur, and go to RAMP on the next cycle.
REQ-021 RAMP: on each tick, each channel moves toward its target by min(SLEW,|target-sp|); the difference is computed at 17-bit signed width, with no wrap.
REQ-022 RAMP: when all four channels equal target, load the hold counter with dur and go to HOLD; if the entry target already equals sp, RAMP exits on the first tick.
REQ-023 HOLD: on each tick with counter > 0, decrement the counter.
REQ-024 HOLD: with counter = 0, pulse done, then pop and go to RAMP if the queue is non-empty, else set target to 0 and go to STOP; dur = 0 therefore ends HOLD without waiting for a tick.
REQ-025 STOP: ramp as in RAMP toward 0; when all channels are 0 go to IDLE; if a command arrives during STOP, pop it and go to RAMP immediately.
REQ-026 sp changes only on a tick or on estop.
REQ-027 sp_valid is asserted in the same cycle sp takes its new value.
REQ-028 estop has priority over every other event.
REQ-029 estop: while high, the next cycle sets sp to 0 (sp_valid pulses if sp was non-zero), flushes the queue, forces state to IDLE, and suppresses both pops and done.
REQ-030 estop: normal operation resumes on the first cycle after estop deasserts.
REQ-031 A push and an estop in the same cycle: no push occurs, because cmd_ready is low.

Reset
REQ-032 Asserting rst asynchronously sets sp=0, sp_valid=0, done=0, busy=0, level=0, state=IDLE, empties the queue and clears the tick counter.
REQ-033 Asserting rst mid-ramp or mid-hold discards all state; there is no resume after reset.
REQ-034 While rst is high, cmd_ready=0.
REQ-035 One cycle after rst deasserts, cmd_ready=1.

Verification (TICK_DIV=4, SLEW=16, DEPTH=4)
REQ-036 Push FL=+40 with dur=2: sp FL steps 16, 32, 40 on successive ticks, holds for 2 ticks, pulses done, ramps 24, 8, 0, then IDLE with busy=0.
REQ-037 Push 5 commands back-to-back with no pop possible: cmd_ready goes low at level=4; the 5th command is accepted after the first pop.
REQ-038 Signed extremes: target -32768 starting from +32767 ramps by 16 per tick with no overflow and reaches -32768 exactly.
REQ-039 estop asserted during HOLD with 2 commands queued: sp=0 on the next cycle, level=0, no done pulse, state IDLE; after release, a new push is accepted.
REQ-040 Two commands with dur=0 and equal targets: done pulses twice with no STOP in between; sp_valid pulses only on value changes.
REQ-041 rst asserted mid-RAMP with sp=48: all outputs are 0 immediately; after release, level=0 and cmd_ready=1.
